// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, requester indices and id-width helper for the PID datapath.
package pid_pkg;
  localparam int PID_W = 16;
  localparam int N_TERMS = 3;
  localparam int TERM_P = 0;
  localparam int TERM_I = 1;
  localparam int TERM_D = 2;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: requester operand bus and result bus of the shared multiplier.
interface mult_share_arbiter_if
  import pid_pkg::*;
#(
  parameter int N_REQ = N_TERMS,
  parameter int W = PID_W,
  parameter int IDW = idw(N_REQ)
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [W-1:0] rsp_data;
  logic [IDW-1:0] rsp_id;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/multiplier.sv
// multiplier: 16x16 unsigned array multiplier keeping the low 16 product bits.
module multiplier (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);
  assign p = a * b;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request after last, gated by en.
module rr_arbiter
  import pid_pkg::*;
#(
  parameter int N = N_TERMS,
  parameter int IDW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic           en,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx
);
  logic found;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(last) + k) % N;
      if (en && !found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        idx = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin time-sharing of one multiplier through a two-stage
// pipeline (operand regs -> multiplier -> result regs) with result back-pressure.
module mult_share_arbiter
  import pid_pkg::*;
#(
  parameter int N_REQ = N_TERMS,
  parameter int W = PID_W,
  parameter int IDW = idw(N_REQ)
) (
  input  logic clk,
  input  logic rst,
  mult_share_arbiter_if.slave bus,
  output logic idle
);
  logic s1_valid, s2_valid, s2_load, s1_free, xfer;
  logic [W-1:0] op_a, op_b, res, prod;
  logic [IDW-1:0] s1_id, s2_id, last_grant, gidx;
  logic [N_REQ-1:0] grant;
  assign s2_load = s1_valid && (!s2_valid || bus.rsp_ready);
  assign s1_free = !s1_valid || s2_load;
  assign xfer = |grant;
  // rst gates grants so req_ready stays low while reset is held
  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_arb (
    .req(bus.req_valid), .en(s1_free && !rst), .last(last_grant),
    .grant(grant), .idx(gidx)
  );
  multiplier u_mul (.a(op_a), .b(op_b), .p(prod));
  assign bus.req_ready = grant;
  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_data = res;
  assign bus.rsp_id = s2_id;
  assign idle = !s1_valid && !s2_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      s1_id <= '0;
      last_grant <= IDW'(N_REQ - 1);
    end else if (xfer) begin
      s1_valid <= 1'b1;
      op_a <= bus.req_a[gidx*W +: W];
      op_b <= bus.req_b[gidx*W +: W];
      s1_id <= gidx;
      last_grant <= gidx;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res <= '0;
      s2_id <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      res <= prod;
      s2_id <= s1_id;
    end else if (bus.rsp_ready) begin
      s2_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed checks of arbitration, pipeline timing, truncation and reset.
module tb_mult_share_arbiter;
  import pid_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idle;
  int checks = 0;
  int failures = 0;
  mult_share_arbiter_if #(.N_REQ(3), .W(16)) bus();
  mult_share_arbiter dut (.clk(clk), .rst(rst), .bus(bus), .idle(idle));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
  endtask
  task automatic single(input string tag, input int i, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp);
    set_op(i, a, b);
    bus.req_valid = 3'(1 << i);
    #1 chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << i));
    @(negedge clk);
    bus.req_valid = '0;
    chk({tag, "_busy"}, 32'(idle), 0);
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 1);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp));
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(i));
    @(negedge clk);
    chk({tag, "_idle"}, 32'(idle), 1);
    chk({tag, "_drained"}, 32'(bus.rsp_valid), 0);
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.req_valid = 3'b111;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_idle", 32'(idle), 1);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    single("single", TERM_P, 16'd3, 16'd7, 16'd21);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) set_op(i, 16'(i + 2), 16'd10);
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) begin
        chk("fair_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("fair_rsp_data", 32'(bus.rsp_data), 32'((((c - 2) % 3) + 2) * 10));
        chk("fair_rsp_id", 32'(bus.rsp_id), 32'((c - 2) % 3));
      end
      bus.req_valid = (c < 6) ? 3'b111 : 3'b000;
      #1 chk("fair_grant", 32'(bus.req_ready), (c < 6) ? 32'(1 << (c % 3)) : 0);
      @(negedge clk);
    end
    chk("fair_idle", 32'(idle), 1);
    single("trunc_ffff", TERM_P, 16'hFFFF, 16'h0002, 16'hFFFE);
    single("trunc_zero", TERM_I, 16'h0100, 16'h0100, 16'h0000);
    for (int r = 0; r < 3; r++) single("sparse", TERM_D, 16'(r + 1), 16'd9, 16'((r + 1) * 9));
    for (int i = 0; i < 3; i++) set_op(i, 16'(i + 5), 16'd3);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 3'b111;
    #1 chk("bp_grant0_after_sparse", 32'(bus.req_ready), 32'b001);
    @(negedge clk);
    chk("bp_grant1", 32'(bus.req_ready), 32'b010);
    @(negedge clk);
    chk("bp_full_ready", 32'(bus.req_ready), 0);
    chk("bp_full_rsp_id", 32'(bus.rsp_id), 0);
    @(negedge clk);
    chk("bp_hold_ready", 32'(bus.req_ready), 0);
    chk("bp_hold_valid", 32'(bus.rsp_valid), 1);
    chk("bp_hold_data", 32'(bus.rsp_data), 15);
    bus.rsp_ready = 1'b1;
    #1 chk("bp_release_grant2", 32'(bus.req_ready), 32'b100);
    @(negedge clk);
    chk("bp_rsp1_data", 32'(bus.rsp_data), 18);
    chk("bp_rsp1_id", 32'(bus.rsp_id), 1);
    bus.req_valid = '0;
    @(negedge clk);
    chk("bp_rsp2_data", 32'(bus.rsp_data), 21);
    chk("bp_rsp2_id", 32'(bus.rsp_id), 2);
    @(negedge clk);
    chk("bp_idle", 32'(idle), 1);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 3'b111;
    repeat (2) @(negedge clk);
    chk("rmid_full_valid", 32'(bus.rsp_valid), 1);
    chk("rmid_full_idle", 32'(idle), 0);
    rst = 1'b1;
    #1;
    chk("rmid_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rmid_idle", 32'(idle), 1);
    chk("rmid_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1 chk("rmid_first_grant", 32'(bus.req_ready), 32'b001);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("rmid_rsp_id", 32'(bus.rsp_id), 0);
    chk("rmid_rsp_data", 32'(bus.rsp_data), 15);
    @(negedge clk);
    chk("rmid_idle_end", 32'(idle), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Time-shares one 16x16 array multiplier (low 16 product bits) among up to N_REQ requesters, normally the P, I and D term units of the PID controller. A round-robin arbiter grants one request per cycle. Operands and results pass through a two-stage registered pipeline with result back-pressure, so the slow combinational array sits between two flops.

## Interface
- N_REQ, 3, number of requesters (2..8)
- W, 16, operand/result width; fixed at 16 to match the multiplier
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester grant; at most one bit set
- req_a  in  N_REQ*W  operand A, requester i at [i*W +: W]
- req_b  in  N_REQ*W  operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_data  out  W  product, low W bits
- rsp_id  out  IDW  index of the requester owning rsp_data; IDW = $clog2(N_REQ)
- idle  out  1  high when both stages are empty

## Operation
**Pipeline stages**
- S1 registers: s1_valid, op_a, op_b, s1_id.
- The multiplier is combinational between S1 and S2.
- S2 registers: s2_valid, res, s2_id.

**Advance rules**
- s2_load = s1_valid && (!s2_valid || rsp_ready).
- s1_free = !s1_valid || s2_load.
- The arbiter grants only when s1_free.
- A transfer occurs on req_valid[i] && req_ready[i]. It loads S1 with requester i's operands and s1_id = i.

**Arbitration**
- Round-robin. Search starts at (last_grant+1) mod N_REQ and picks the first asserted req_valid.
- last_grant updates only on a transfer.
- last_grant resets to N_REQ-1, so requester 0 has first priority after reset.
- req_ready is combinational from req_valid, last_grant and s1_free. Requesters must not make req_valid depend on req_ready.
- A requester holds req_valid and operands stable until its transfer.

**Arithmetic**
- res = (op_a * op_b) mod 2^16, unsigned. Upper bits are discarded with no overflow flag.

**Outputs**
- rsp_valid = s2_valid; rsp_data = res; rsp_id = s2_id.
- A result is consumed on rsp_valid && rsp_ready.
- idle = !s1_valid && !s2_valid.

**Reset values**
- req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, idle = 1.
- All internal valids = 0, last_grant = N_REQ-1.

**Boundary conditions**
- **Simultaneous consume and load:** S2 consumed while S1 loads into S2 in the same cycle means no bubble. S1 may also accept a new request in that cycle.
- **Full pipeline:** both stages valid and rsp_ready = 0 means req_ready = 0 for all; S1 and S2 hold their values.
- **Wrap-around:** when last_grant = N_REQ-1, the search starts at 0.
- **Reset mid-operation:** in-flight operations are dropped with no response, and the arbiter pointer returns to its reset value.
- **No requests:** last_grant and S1 are unchanged, and s1_valid clears once S1 has moved to S2.

## Timing
- **Latency:** a transfer at clock edge k makes rsp_valid high after edge k+1, i.e. 2 cycles from the request cycle when rsp_ready = 1.
- **Throughput:** 1 result per cycle while rsp_ready stays high.
- **Fairness:** with all N_REQ requesters continuously valid, each is granted exactly once every N_REQ cycles.
- **Back-pressure:** rsp_ready low for one cycle inserts exactly one grant-less cycle once S1 fills.
- **Critical path:** the multiplier lies entirely between S1 and S2 flops. The arbiter to req_ready path is combinational but shallow.

## Structure
- Shared package pid_pkg holds:
  - PID_W = 16 and N_TERMS = 3;
  - requester index constants TERM_P = 0, TERM_I = 1, TERM_D = 2;
  - the IDW derivation.
- Sub-module rr_arbiter (parameter N): takes req, en and last-grant state, and outputs a one-hot grant and the grant index.
- The existing 16x16 `multiplier` is instantiated unchanged between S1 and S2.

## Test plan
- **Single request:** after reset, req_valid = 3'b001 with a = 3, b = 7 -> req_ready[0] in the same cycle; rsp_valid 2 cycles later with rsp_data = 21, rsp_id = 0.
- **Fairness and order:** all three valid for 6 cycles with a = i+2, b = 10 -> grant order 0,1,2,0,1,2; responses 20,30,40 repeat in the same order with matching rsp_id.
- **Truncation:** a = 16'hFFFF, b = 16'h0002 -> rsp_data = 16'hFFFE. Separately, a = 16'h0100, b = 16'h0100 -> rsp_data = 0.
- **Back-pressure:** rsp_ready = 0 with continuous requests -> exactly 2 operations accepted, then req_ready = 0. Raising rsp_ready -> results delivered in order with none lost or duplicated.
- **Reset mid-operation:** assert rst with both stages valid -> rsp_valid drops immediately and idle = 1. After release, the first grant goes to requester 0.
- **Sparse requests:** only requester 2 valid on alternate cycles -> every request granted the cycle it is raised, idle pulses between results, and last_grant stays 2.
